checksum_arbiter: RTL

//   Round-robin arbiter/sequencer that shares one checksum unit among NUM_REQ requesters.

---
 rtl/checksum_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/checksum_arbiter.sv
// rtl/checksum_arbiter.sv - round-robin sequencer sharing one checksum unit among NUM_REQ requesters (optional CKSUM_ARB_FAILCNT_EN)
module checksum_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CK_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ*16-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]      o_gnt,
    output logic [NUM_REQ-1:0]      o_done,
    output logic                    o_result,
    output logic                    o_busy,
    output logic [15:0]             o_ck_buffer,
    output logic                    o_ck_start,
    input  logic                    i_ck_valid,
    output logic [15:0]             o_fail_cnt
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (CK_LATENCY > 1) ? $clog2(CK_LATENCY) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(CK_LATENCY - 1);
    localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_idx;
    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic               r_result;
    logic               r_busy;
    logic [15:0]        r_ck_buffer;
    logic               r_ck_start;

    logic               w_found;
    logic [IW-1:0]      w_pick;
    logic [15:0]        w_word;

    // Round-robin scan: first asserted request starting at r_rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
        w_word = i_req_data[16*int'(w_pick) +: 16];
    end

    // Sequencer FSM; every output is registered here so pulses line up with state entry
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_result    <= 1'b0;
            r_busy      <= 1'b0;
            r_ck_buffer <= 16'h0000;
            r_ck_start  <= 1'b0;
        end else begin
            r_gnt      <= '0;
            r_done     <= '0;
            r_ck_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx       <= w_pick;
                        r_ck_buffer <= w_word;
                        r_gnt       <= ONE_HOT0 << w_pick;
                        r_ck_start  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_result <= i_ck_valid;
                        r_done   <= ONE_HOT0 << r_idx;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_busy      = r_busy;
    assign o_ck_buffer = r_ck_buffer;
    assign o_ck_start  = r_ck_start;

`ifdef CKSUM_ARB_FAILCNT_EN
    logic [15:0] r_fail_cnt;

    // Saturating count of invalid verdicts, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fail_cnt <= 16'h0000;
        end else if (r_state == S_RESP && !r_result && r_fail_cnt != 16'hFFFF) begin
            r_fail_cnt <= r_fail_cnt + 16'h0001;
        end
    end

    assign o_fail_cnt = r_fail_cnt;
`else
    assign o_fail_cnt = 16'h0000;
`endif

endmodule
